pipe_flush_ctrl: RTL and testbench

Central stall/flush scheduler for the dual-issue pipeline. Merges per-stage stall requests into the `stall[3:0]` vector consumed by every pipeline register, including the EX/MEM register. Arbitrates exception and branch-mispredict redirects into a one-cycle `flush` with `flush_cause` and a redirect PC. After an exception flush it holds fetch quiet for a programmable refill window.

---
 rtl/pipe_flush_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_flush_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: central stall/flush scheduler for the dual-issue pipeline.
// Merges per-stage hold requests into the stall vector and arbitrates
// exception / mispredict redirects into a one-cycle registered flush.
// After an exception flush, fetch is held quiet for QUIESCE_CYCLES cycles.
module pipe_flush_ctrl #(
  parameter int unsigned QUIESCE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        stallreq_wb,
  input  logic        excp_valid,
  input  logic [31:0] excp_target,
  input  logic        bpu_mispredict,
  input  logic [31:0] bpu_target,
  output logic [3:0]  stall,
  output logic        flush,
  output logic        flush_cause,
  output logic [31:0] new_pc,
  output logic        redirect_busy
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PEND_BR,
    ST_FLUSH_EXC,
    ST_FLUSH_BR,
    ST_QUIESCE
  } state_t;

  // Counter load value on entry to QUIESCE; the counter counts down to zero.
  localparam logic [3:0] LP_Q_INIT =
    (QUIESCE_CYCLES == 0) ? 4'd0 : 4'(QUIESCE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_flush;
  logic        r_cause;
  logic [31:0] r_new_pc;
  logic [31:0] r_pend_pc;

  logic [3:0]  w_base;
  logic [3:0]  w_stall;
  logic        w_excp_ok;

  // Base stall vector: the highest requesting stage stops itself and all older stages.
  always_comb begin
    w_base = 4'b0000;
    if (stallreq_wb)       w_base = 4'b1111;
    else if (stallreq_mem) w_base = 4'b0111;
    else if (stallreq_ex)  w_base = 4'b0011;
    else if (stallreq_id)  w_base = 4'b0001;
  end

  // Final stall: fetch held during QUIESCE, everything released while in reset.
  always_comb begin
    w_stall = w_base;
    if (r_state == ST_QUIESCE) w_stall[0] = 1'b1;
    if (rst) w_stall = 4'b0000;
  end

  // An exception can only commit when MEM and WB are both free to move.
  assign w_excp_ok = excp_valid && !stallreq_mem && !stallreq_wb;

  // Redirect FSM with registered flush, cause and redirect PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_flush   <= 1'b0;
      r_cause   <= 1'b0;
      r_new_pc  <= '0;
      r_pend_pc <= '0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_excp_ok) begin
            r_state  <= ST_FLUSH_EXC;
            r_flush  <= 1'b1;
            r_cause  <= 1'b1;
            r_new_pc <= excp_target;
          end else if (bpu_mispredict) begin
            if (!w_stall[1]) begin
              r_state  <= ST_FLUSH_BR;
              r_flush  <= 1'b1;
              r_cause  <= 1'b0;
              r_new_pc <= bpu_target;
            end else begin
              r_state   <= ST_PEND_BR;
              r_pend_pc <= bpu_target;
            end
          end
        end
        ST_PEND_BR: begin
          if (w_excp_ok) begin
            r_state  <= ST_FLUSH_EXC;
            r_flush  <= 1'b1;
            r_cause  <= 1'b1;
            r_new_pc <= excp_target;
          end else if (!w_stall[1]) begin
            r_state  <= ST_FLUSH_BR;
            r_flush  <= 1'b1;
            r_cause  <= 1'b0;
            r_new_pc <= r_pend_pc;
          end
        end
        ST_FLUSH_EXC: begin
          if (QUIESCE_CYCLES == 0) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_QUIESCE;
            r_cnt   <= LP_Q_INIT;
          end
        end
        ST_FLUSH_BR: begin
          if (w_excp_ok) begin
            r_state  <= ST_FLUSH_EXC;
            r_flush  <= 1'b1;
            r_cause  <= 1'b1;
            r_new_pc <= excp_target;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_QUIESCE: begin
          if (r_cnt == 4'd0) r_state <= ST_RUN;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign stall         = w_stall;
  assign flush         = r_flush;
  assign flush_cause   = r_cause;
  assign new_pc        = r_new_pc;
  assign redirect_busy = (r_state != ST_RUN);

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl with hand-computed expectations.
module tb_pipe_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem, stallreq_wb;
  logic        excp_valid;
  logic [31:0] excp_target;
  logic        bpu_mispredict;
  logic [31:0] bpu_target;
  logic [3:0]  stall;
  logic        flush, flush_cause, redirect_busy;
  logic [31:0] new_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pipe_flush_ctrl #(.QUIESCE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem), .stallreq_wb(stallreq_wb),
    .excp_valid(excp_valid), .excp_target(excp_target),
    .bpu_mispredict(bpu_mispredict), .bpu_target(bpu_target),
    .stall(stall), .flush(flush), .flush_cause(flush_cause),
    .new_pc(new_pc), .redirect_busy(redirect_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic f, input logic c,
                         input logic [31:0] pc, input logic b, input logic [3:0] s);
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
    check({tag, ".cause"}, {31'd0, flush_cause}, {31'd0, c});
    check({tag, ".pc"}, new_pc, pc);
    check({tag, ".busy"}, {31'd0, redirect_busy}, {31'd0, b});
    check({tag, ".stall"}, {28'd0, stall}, {28'd0, s});
  endtask

  initial begin
    rst = 1'b1;
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; stallreq_wb = 1;
    excp_valid = 0; excp_target = '0; bpu_mispredict = 0; bpu_target = '0;
    #1;
    check("rst_stall_forced", {28'd0, stall}, 32'h0);
    tick(); tick();
    stallreq_wb = 0; #1;
    chk_out("reset", 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000);
    rst = 1'b0;

    // Base stall vector from highest requester
    stallreq_ex = 1; #1; check("stall_ex", {28'd0, stall}, 32'h3);
    stallreq_mem = 1; #1; check("stall_mem", {28'd0, stall}, 32'h7);
    stallreq_wb = 1; #1; check("stall_wb", {28'd0, stall}, 32'hF);
    stallreq_wb = 0; stallreq_mem = 0; stallreq_ex = 0; stallreq_id = 1; #1;
    check("stall_id", {28'd0, stall}, 32'h1);
    stallreq_id = 0; tick();
    chk_out("stall_none", 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000);

    // Exception flush then 2-cycle quiesce
    excp_valid = 1; excp_target = 32'hBFC00380;
    tick();
    excp_valid = 0; #1;
    chk_out("exc_flush", 1'b1, 1'b1, 32'hBFC00380, 1'b1, 4'b0000);
    excp_valid = 1; excp_target = 32'h11111111; bpu_mispredict = 1; bpu_target = 32'h22222222;
    tick();
    chk_out("quiesce1", 1'b0, 1'b1, 32'hBFC00380, 1'b1, 4'b0001);
    tick();
    excp_valid = 0; bpu_mispredict = 0; #1;
    chk_out("quiesce2", 1'b0, 1'b1, 32'hBFC00380, 1'b1, 4'b0001);
    tick();
    chk_out("exc_done", 1'b0, 1'b1, 32'hBFC00380, 1'b0, 4'b0000);

    // Mispredict delayed by EX stall
    bpu_mispredict = 1; bpu_target = 32'h80001000; stallreq_ex = 1;
    tick();
    bpu_mispredict = 0; bpu_target = 32'hDEADBEEF; #1;
    chk_out("pend1", 1'b0, 1'b1, 32'hBFC00380, 1'b1, 4'b0011);
    tick();
    chk_out("pend2", 1'b0, 1'b1, 32'hBFC00380, 1'b1, 4'b0011);
    tick();
    chk_out("pend3", 1'b0, 1'b1, 32'hBFC00380, 1'b1, 4'b0011);
    stallreq_ex = 0;
    tick();
    chk_out("br_flush", 1'b1, 1'b0, 32'h80001000, 1'b1, 4'b0000);
    tick();
    chk_out("br_done", 1'b0, 1'b0, 32'h80001000, 1'b0, 4'b0000);

    // Exception and mispredict in the same cycle: exception wins
    excp_valid = 1; excp_target = 32'h12345678; bpu_mispredict = 1; bpu_target = 32'h80002000;
    tick();
    excp_valid = 0; bpu_mispredict = 0; #1;
    chk_out("prio", 1'b1, 1'b1, 32'h12345678, 1'b1, 4'b0000);
    tick();
    check("prio_single", {31'd0, flush}, 32'h0);
    tick(); tick();
    check("prio_run", {31'd0, redirect_busy}, 32'h0);

    // Exception blocked by MEM stall
    excp_valid = 1; excp_target = 32'hA0000180; stallreq_mem = 1;
    tick();
    chk_out("blk1", 1'b0, 1'b1, 32'h12345678, 1'b0, 4'b0111);
    tick();
    chk_out("blk2", 1'b0, 1'b1, 32'h12345678, 1'b0, 4'b0111);
    stallreq_mem = 0;
    tick();
    excp_valid = 0; #1;
    chk_out("blk_flush", 1'b1, 1'b1, 32'hA0000180, 1'b1, 4'b0000);
    tick(); tick(); tick();
    check("blk_run", {31'd0, redirect_busy}, 32'h0);

    // Back-to-back FLUSH_BR then FLUSH_EXC
    bpu_mispredict = 1; bpu_target = 32'h80003000;
    tick();
    bpu_mispredict = 0; excp_valid = 1; excp_target = 32'h80000080; #1;
    chk_out("b2b_br", 1'b1, 1'b0, 32'h80003000, 1'b1, 4'b0000);
    tick();
    excp_valid = 0; #1;
    chk_out("b2b_exc", 1'b1, 1'b1, 32'h80000080, 1'b1, 4'b0000);
    tick(); tick(); tick();
    check("b2b_run", {31'd0, redirect_busy}, 32'h0);

    // Pending branch discarded by a later exception
    bpu_mispredict = 1; bpu_target = 32'h80004000; stallreq_ex = 1;
    tick();
    bpu_mispredict = 0; excp_valid = 1; excp_target = 32'h80000200;
    tick();
    excp_valid = 0; #1;
    chk_out("pend_exc", 1'b1, 1'b1, 32'h80000200, 1'b1, 4'b0011);
    stallreq_ex = 0;
    tick(); tick(); tick();
    chk_out("pend_exc_done", 1'b0, 1'b1, 32'h80000200, 1'b0, 4'b0000);

    // Reset during QUIESCE
    excp_valid = 1; excp_target = 32'hBFC00400;
    tick();
    excp_valid = 0;
    tick(); #1;
    check("rq_in_quiesce", {28'd0, stall}, 32'h1);
    rst = 1; stallreq_wb = 1; #1;
    check("rq_stall_rst", {28'd0, stall}, 32'h0);
    tick();
    chk_out("rq_reset", 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000);
    rst = 0; #1;
    check("rq_stall_after", {28'd0, stall}, 32'hF);
    stallreq_wb = 0;
    tick();
    chk_out("rq_run", 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
